// File: rtl/seq_pkg.sv
// Shared definitions for the control sequencer: state encoding and program word layout.
package seq_pkg;

    localparam int INSTR_W  = 4;
    localparam int HALT_BIT = 3;
    localparam int CODE_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[HALT_BIT];
    endfunction

    function automatic logic [CODE_W-1:0] code_of(input logic [INSTR_W-1:0] word);
        return word[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Program-load, run-control and datapath-control signals of the sequencer.
interface ctrl_sequencer_if
    import seq_pkg::*;
#(
    parameter int AW = 4
);
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               start;
    logic               pause;
    logic [CODE_W-1:0]  control;
    logic               ctrl_valid;
    logic [AW-1:0]      pc;
    logic               busy;
    logic               done;

    modport master (
        output prog_we, prog_addr, prog_data, start, pause,
        input  control, ctrl_valid, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, pause,
        output control, ctrl_valid, pc, busy, done
    );

endinterface

// File: rtl/seq_prog_mem.sv
// Program store: one write port, one registered read port, contents survive reset.
module seq_prog_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
)(
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    // Write-first forwarding so a word loaded on the same edge as start is the one fetched.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Replays a loaded program of control words to the datapath, each held HOLD cycles,
// stopping on a halt word or after the last memory word.
module ctrl_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int HOLD  = 2
)(
    input  logic             clk,
    input  logic             rst,
    ctrl_sequencer_if.slave  bus
);

    localparam int              CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
    localparam logic [AW-1:0]   PC_LAST  = AW'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_pc;
    logic [AW-1:0]       w_pc_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [CODE_W-1:0]   r_control;
    logic [CODE_W-1:0]  w_control_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_busy;
    logic                w_mem_we;
    logic [INSTR_W-1:0]  w_rdata;

    assign w_busy   = (r_state == S_FETCH) || (r_state == S_ISSUE);
    assign w_mem_we = bus.prog_we && !w_busy;

    // Read address is the next pc, so the word is already registered during FETCH.
    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_data),
        .i_raddr (w_pc_nxt),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_control <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_control <= w_control_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_control_nxt = r_control;
        w_valid_nxt   = r_valid;
        w_done_nxt    = r_done;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                if (is_halt(w_rdata)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt   = S_ISSUE;
                    w_control_nxt = code_of(w_rdata);
                    w_valid_nxt   = 1'b1;
                    w_cnt_nxt     = '0;
                end
            end

            S_ISSUE: begin
                // pause freezes the hold count and keeps the word on the bus.
                if (!bus.pause) begin
                    if (r_cnt == CNT_LAST) begin
                        w_control_nxt = '0;
                        w_valid_nxt   = 1'b0;
                        w_cnt_nxt     = '0;
                        if (r_pc == PC_LAST) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_pc_nxt    = r_pc + AW'(1);
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end

            S_DONE: begin
                if (bus.start) begin
                    w_done_nxt  = 1'b0;
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.control    = r_control;
    assign bus.ctrl_valid = r_valid;
    assign bus.pc         = r_pc;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: cycle tables for run/pause plus hand sequences.
module tb_ctrl_sequencer;
    import seq_pkg::*;

    logic clk;
    logic rst;

    ctrl_sequencer_if #(.AW(4)) bus ();

    ctrl_sequencer #(
        .DEPTH (16),
        .AW    (4),
        .HOLD  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       start;
        logic       pause;
        logic [2:0] ctrl;
        logic       vld;
        logic [3:0] pc;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] seen[$];
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outs_now();
        return {bus.control, bus.ctrl_valid, bus.pc, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [3:0] addr, input logic [3:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic [2:0] c,
                                input logic v, input logic [3:0] pcv, input logic b,
                                input logic d);
        vec_t r;
        r.start = s; r.pause = p; r.ctrl = c; r.vld = v;
        r.pc = pcv; r.busy = b; r.done = d;
        return r;
    endfunction

    // Pulses start and follows the run to done; records the code of each issued word.
    task automatic run_prog(output int cyc, output bit to);
        logic prev_v;
        seen.delete();
        to = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        prev_v = 1'b0;
        while (!bus.done) begin
            if (bus.ctrl_valid && !prev_v) seen.push_back(bus.control);
            prev_v = bus.ctrl_valid;
            if (cyc >= 200) begin
                to = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        int  cyc;
        bit  to;
        int  n;
        logic [9:0] exp;

        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        #12;
        rst = 1'b0;
        tick();
        chk("reset_outputs", 32'(outs_now()), 32'd0);

        prog_write(4'd0, 4'h1);
        prog_write(4'd1, 4'h5);
        prog_write(4'd2, 4'h8);

        // Normal run, then a paused run restarted from DONE.
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start = vecs[i].start;
            bus.pause = vecs[i].pause;
            tick();
            exp = {vecs[i].ctrl, vecs[i].vld, vecs[i].pc, vecs[i].busy, vecs[i].done};
            chk($sformatf("vec%0d", i), 32'(outs_now()), 32'(exp));
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;

        // start and prog_we while busy are dropped.
        bus.start = 1'b1;
        tick();
        chk("busy_fetch", 32'(outs_now()), 32'({3'd0, 1'b0, 4'd0, 1'b1, 1'b0}));
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd1;
        bus.prog_data = 4'h7;
        tick();
        chk("busy_ign_a", 32'({bus.control, bus.pc}), 32'({3'd1, 4'd0}));
        tick();
        chk("busy_ign_b", 32'({bus.control, bus.pc}), 32'({3'd1, 4'd0}));
        tick();
        chk("busy_ign_c", 32'({bus.control, bus.pc}), 32'({3'd0, 4'd1}));
        tick();
        chk("busy_ign_d", 32'({bus.control, bus.pc}), 32'({3'd5, 4'd1}));
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        chk("busy_run_done", 32'({bus.done, bus.pc}), 32'({1'b1, 4'd2}));
        run_prog(cyc, to);
        chk("readback_timeout", 32'(to), 32'd0);
        chk("readback_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("readback_w0", 32'(seen[0]), 32'd1);
            chk("readback_w1", 32'(seen[1]), 32'd5);
        end
        chk("readback_cycles", 32'(cyc), 32'd8);

        // Asynchronous reset in the middle of ISSUE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("pre_reset_issue", 32'({bus.control, bus.ctrl_valid}), 32'({3'd1, 1'b1}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 32'(outs_now()), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_reset_idle", 32'(outs_now()), 32'd0);
        run_prog(cyc, to);
        chk("restart_timeout", 32'(to), 32'd0);
        chk("restart_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("restart_w0", 32'(seen[0]), 32'd1);
            chk("restart_w1", 32'(seen[1]), 32'd5);
        end
        chk("restart_pc", 32'(bus.pc), 32'd2);
        chk("restart_cycles", 32'(cyc), 32'd8);

        // Full memory without a halt word ends at the last address.
        for (int a = 0; a < 16; a++) prog_write(4'(a), 4'h2);
        run_prog(cyc, to);
        chk("eom_timeout", 32'(to), 32'd0);
        chk("eom_count", 32'(seen.size()), 32'd16);
        n = 0;
        foreach (seen[k]) if (seen[k] != 3'd2) n++;
        chk("eom_codes", 32'(n), 32'd0);
        chk("eom_cycles", 32'(cyc), 32'd49);
        chk("eom_end", 32'(outs_now()), 32'({3'd0, 1'b0, 4'd15, 1'b0, 1'b1}));
        tick();
        chk("eom_hold", 32'(outs_now()), 32'({3'd0, 1'b0, 4'd15, 1'b0, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
